// File: rtl/sdrxframe_if.sv
// Sample-in / word-out stream bundle for the SDIO receive deframer.
// The deframer takes the slave view; the front end / buffer side takes master.
interface sdrxframe_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        M_VALID;
   logic [31:0] M_DATA;
   logic        M_LAST;

   modport slave  (input rx_valid, rx_data, output M_VALID, M_DATA, M_LAST);
   modport master (output rx_valid, rx_data, input M_VALID, M_DATA, M_LAST);
endinterface

// File: rtl/sdrxframe.sv
// SDIO receive data-frame deframer: start-bit hunt, MSB-first word packing, per-lane CRC16 and end-bit check.
// Define SDRXFRAME_TIMEOUT_EN to add i_timeout and a start-bit timeout in WAIT.
module sdrxframe #(
   parameter int              NCRC           = 16,
   parameter logic [NCRC-1:0] CRC_POLYNOMIAL = 16'h1021,
   parameter int              LGLEN          = 10
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [1:0]       i_cfg_width,
   input  logic             i_cfg_ddr,
   input  logic [LGLEN-1:0] i_length,
   input  logic             i_en,
`ifdef SDRXFRAME_TIMEOUT_EN
   input  logic [23:0]      i_timeout,
`endif
   sdrxframe_if.slave       bus,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_ENDB} state_t;
   state_t state, state_nx;

   logic [1:0]       width_r;
   logic             ddr_r;
   logic [LGLEN-1:0] bytes_r;
   logic             skip_r, phase_r, end_seen_r, end_bad_r;
   logic [4:0]       smp_cnt, word_last_idx;
   logic [31:0]      acc, acc_nx;
   logic [7:0]       lane_mask;
   // Index 0..7 = lane on rising edge (or SDR), 8..15 = lane on falling edge
   logic [NCRC-1:0]  crc_calc [16];
   logic [NCRC-1:0]  crc_rcv  [16];

   logic arm, start_det, tmo_fire, dat_shift, crc_shift, end_smp, frame_fin;
   logic word_end, last_word, crc_end, crc_bad, end_bad_now;

   function automatic logic [NCRC-1:0] crc_step(input logic [NCRC-1:0] c, input logic b);
      return {c[NCRC-2:0], 1'b0} ^ ((c[NCRC-1] ^ b) ? CRC_POLYNOMIAL : '0);
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (i_en) state_nx = S_WAIT;
         S_WAIT: if (!i_en || tmo_fire) state_nx = S_IDLE;
                 else if (start_det)    state_nx = S_DATA;
         S_DATA: if (!i_en)             state_nx = S_IDLE;
                 else if (last_word)    state_nx = S_CRC;
         S_CRC:  if (!i_en)             state_nx = S_IDLE;
                 else if (crc_shift && crc_end) state_nx = S_ENDB;
         S_ENDB: if (!i_en || frame_fin) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != S_IDLE);
      case (width_r)
         2'b00:   begin lane_mask = 8'h01; word_last_idx = 5'd31; acc_nx = {acc[30:0], bus.rx_data[0]};   end
         2'b01:   begin lane_mask = 8'h0F; word_last_idx = 5'd7;  acc_nx = {acc[27:0], bus.rx_data[3:0]}; end
         default: begin lane_mask = 8'hFF; word_last_idx = 5'd3;  acc_nx = {acc[23:0], bus.rx_data};      end
      endcase
      arm         = (state == S_IDLE) && i_en;
      start_det   = (state == S_WAIT) && i_en && bus.rx_valid && !bus.rx_data[0];
      dat_shift   = (state == S_DATA) && i_en && bus.rx_valid && !skip_r;
      crc_shift   = (state == S_CRC)  && i_en && bus.rx_valid;
      end_smp     = (state == S_ENDB) && i_en && bus.rx_valid;
      frame_fin   = end_smp && (!ddr_r || end_seen_r);
      word_end    = (smp_cnt == word_last_idx);
      last_word   = dat_shift && word_end && (bytes_r == LGLEN'(4));
      crc_end     = (smp_cnt == (ddr_r ? 5'd31 : 5'd15));
      end_bad_now = |(lane_mask & ~bus.rx_data);
   end

   always_comb begin
      crc_bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (lane_mask[i] && (crc_calc[i] != crc_rcv[i]))                 crc_bad = 1'b1;
         if (lane_mask[i] && ddr_r && (crc_calc[i+8] != crc_rcv[i+8]))   crc_bad = 1'b1;
      end
   end

`ifdef SDRXFRAME_TIMEOUT_EN
   logic [23:0] tmo_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset)                                tmo_cnt <= '0;
      else if (arm)                               tmo_cnt <= i_timeout;
      else if (state == S_WAIT && tmo_cnt != '0)  tmo_cnt <= tmo_cnt - 24'd1;
   end

   // Fires on the cycle the counter steps from 1 to 0; a zero load never fires
   assign tmo_fire = (state == S_WAIT) && i_en && !start_det && (tmo_cnt == 24'd1);
`else
   assign tmo_fire = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         width_r     <= '0;
         ddr_r       <= 1'b0;
         bytes_r     <= '0;
         skip_r      <= 1'b0;
         phase_r     <= 1'b0;
         end_seen_r  <= 1'b0;
         end_bad_r   <= 1'b0;
         smp_cnt     <= '0;
         acc         <= '0;
         bus.M_VALID <= 1'b0;
         bus.M_DATA  <= '0;
         bus.M_LAST  <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            crc_calc[i] <= '0;
            crc_rcv[i]  <= '0;
         end
      end else begin
         bus.M_VALID <= 1'b0;
         bus.M_LAST  <= 1'b0;
         o_done      <= 1'b0;
         if (arm) begin
            width_r    <= i_cfg_width;
            ddr_r      <= i_cfg_ddr;
            bytes_r    <= i_length;
            o_err      <= 1'b0;
            skip_r     <= 1'b0;
            phase_r    <= 1'b0;
            end_seen_r <= 1'b0;
            end_bad_r  <= 1'b0;
            smp_cnt    <= '0;
            acc        <= '0;
            for (int i = 0; i < 16; i++) begin
               crc_calc[i] <= '0;
               crc_rcv[i]  <= '0;
            end
         end
         // DDR: the falling half of the start bit arrives as the first DATA sample
         if (start_det) skip_r <= ddr_r;
         if (state == S_DATA && bus.rx_valid && skip_r) skip_r <= 1'b0;
         if (dat_shift) begin
            acc     <= acc_nx;
            phase_r <= ddr_r & ~phase_r;
            smp_cnt <= word_end ? 5'd0 : smp_cnt + 5'd1;
            for (int l = 0; l < 8; l++) begin
               if (phase_r) crc_calc[l+8] <= crc_step(crc_calc[l+8], bus.rx_data[l]);
               else         crc_calc[l]   <= crc_step(crc_calc[l],   bus.rx_data[l]);
            end
            if (word_end) begin
               bus.M_VALID <= 1'b1;
               bus.M_DATA  <= acc_nx;
               bus.M_LAST  <= last_word;
               bytes_r     <= bytes_r - LGLEN'(4);
            end
         end
         if (crc_shift) begin
            phase_r <= ddr_r & ~phase_r;
            smp_cnt <= smp_cnt + 5'd1;
            for (int l = 0; l < 8; l++) begin
               if (phase_r) crc_rcv[l+8] <= {crc_rcv[l+8][NCRC-2:0], bus.rx_data[l]};
               else         crc_rcv[l]   <= {crc_rcv[l][NCRC-2:0],   bus.rx_data[l]};
            end
         end
         if (end_smp) begin
            if (frame_fin) begin
               o_done <= 1'b1;
               o_err  <= crc_bad | (ddr_r ? end_bad_r : end_bad_now);
            end else begin
               end_seen_r <= 1'b1;
               end_bad_r  <= end_bad_now;
            end
         end
         if (tmo_fire) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdrxframe.sv
// Directed bench for sdrxframe: 1W/4W SDR and 8W DDR frames, CRC and end-bit errors,
// gapped samples, abort with re-arm, and the WAIT timeout when SDRXFRAME_TIMEOUT_EN is defined.
module tb_sdrxframe;

   logic       i_clk = 1'b0;
   logic       i_reset, i_cfg_ddr, i_en;
   logic [1:0] i_cfg_width;
   logic [9:0] i_length;
   logic       o_busy, o_done, o_err;
`ifdef SDRXFRAME_TIMEOUT_EN
   logic [23:0] i_timeout;
`endif

   sdrxframe_if bus();

   sdrxframe dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_cfg_width (i_cfg_width),
      .i_cfg_ddr   (i_cfg_ddr),
      .i_length    (i_length),
      .i_en        (i_en),
`ifdef SDRXFRAME_TIMEOUT_EN
      .i_timeout   (i_timeout),
`endif
      .bus         (bus),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   int          nchecks = 0;
   int          nerr    = 0;
   logic [31:0] got_w [$];
   logic        got_l [$];
   int          done_cnt = 0;
   int          overlap  = 0;
   logic        last_err = 1'b0;
   int          w_base, d_base;
   logic [31:0] wexp [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
      return (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   initial forever begin
      @(negedge i_clk);
      if (bus.M_VALID) begin
         got_w.push_back(bus.M_DATA);
         got_l.push_back(bus.M_LAST);
      end
      if (o_done) begin
         done_cnt++;
         last_err = o_err;
      end
      if (bus.M_VALID && o_done) overlap++;
   end

   task automatic send(input logic [7:0] d, input bit gaps);
      if (gaps && $urandom_range(0, 1) == 1) begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'h00;
         @(posedge i_clk); #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
      @(posedge i_clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   // Builds and drives one frame from wexp[]; abort_at >= 0 drops i_en before that data sample.
   task automatic run_frame(input int w, input bit ddr, input int len, input int flip_lane,
                            input int flip_bit, input logic [7:0] end0, input bit gaps, input int abort_at);
      logic [15:0] crc [2][8];
      logic [7:0]  d;
      int          k, e, b, nw, spw;
      for (int x = 0; x < 2; x++)
         for (int n = 0; n < 8; n++) crc[x][n] = 16'h0000;
      nw  = len / 4;
      spw = 32 / w;
      w_base = got_w.size();
      d_base = done_cnt;
      i_cfg_width = (w == 1) ? 2'b00 : (w == 4) ? 2'b01 : 2'b10;
      i_cfg_ddr   = ddr;
      i_length    = 10'(len);
      i_en        = 1'b1;
      @(posedge i_clk); #1;
      send(8'hFF, gaps);
      send(8'h00, gaps);
      if (ddr) send(8'h00, gaps);
      k = 0;
      for (int i = 0; i < nw; i++) begin
         for (int s = 0; s < spw; s++) begin
            if (k == abort_at) begin
               i_en = 1'b0;
               @(posedge i_clk); #1;
               check("abort.busy", 32'(o_busy), 32'd0);
               repeat (4) send(8'h0F, 1'b0);
               return;
            end
            d = 8'h00;
            e = ddr ? (k % 2) : 0;
            for (int n = 0; n < w; n++) begin
               b = 31 - s * w - (w - 1 - n);
               d[n] = wexp[i][b];
               crc[e][n] = crc16_bit(crc[e][n], d[n]);
            end
            send(d, gaps);
            k++;
         end
      end
      if (flip_lane >= 0) crc[0][flip_lane][flip_bit] = ~crc[0][flip_lane][flip_bit];
      for (int j = 0; j < (ddr ? 32 : 16); j++) begin
         d = 8'h00;
         e = ddr ? (j % 2) : 0;
         for (int n = 0; n < w; n++) d[n] = crc[e][n][15 - (ddr ? j / 2 : j)];
         send(d, gaps);
      end
      send(end0, gaps);
      if (ddr) send(8'h00, gaps);
      i_en = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input int nw, input logic eerr);
      int t;
      t = 0;
      while (done_cnt == d_base && t < 100) begin
         @(posedge i_clk); #1;
         t++;
      end
      repeat (2) @(posedge i_clk);
      #1;
      check({tag, ".done"}, 32'(done_cnt - d_base), 32'd1);
      check({tag, ".nwords"}, 32'(got_w.size() - w_base), 32'(nw));
      for (int i = 0; i < nw; i++) begin
         if (w_base + i < got_w.size()) begin
            check($sformatf("%s.word%0d", tag, i), got_w[w_base + i], wexp[i]);
            check($sformatf("%s.last%0d", tag, i), 32'(got_l[w_base + i]), 32'(i == nw - 1));
         end
      end
      check({tag, ".err"}, 32'(last_err), 32'(eerr));
      check({tag, ".busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      i_reset      = 1'b1;
      i_en         = 1'b0;
      i_cfg_width  = 2'b00;
      i_cfg_ddr    = 1'b0;
      i_length     = 10'd0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
`ifdef SDRXFRAME_TIMEOUT_EN
      i_timeout    = 24'd0;
`endif
      repeat (3) @(posedge i_clk);
      #1;
      check("rst.busy",   32'(o_busy),      32'd0);
      check("rst.done",   32'(o_done),      32'd0);
      check("rst.err",    32'(o_err),       32'd0);
      check("rst.mvalid", 32'(bus.M_VALID), 32'd0);
      check("rst.mlast",  32'(bus.M_LAST),  32'd0);
      check("rst.mdata",  bus.M_DATA,       32'd0);
      i_reset = 1'b0;
      @(posedge i_clk); #1;

      wexp[0] = 32'hDEADBEEF;
      run_frame(1, 1'b0, 4, -1, 0, 8'hFF, 1'b0, -1);
      expect_frame("w1", 1, 1'b0);

      wexp[0] = 32'h01234567;
      wexp[1] = 32'h89ABCDEF;
      run_frame(4, 1'b0, 8, -1, 0, 8'hFF, 1'b0, -1);
      expect_frame("w4", 2, 1'b0);
      run_frame(4, 1'b0, 8, 2, 5, 8'hFF, 1'b0, -1);
      expect_frame("w4_crcbad", 2, 1'b1);

      wexp[0] = 32'h11223344;
      run_frame(8, 1'b1, 4, -1, 0, 8'hFF, 1'b0, -1);
      expect_frame("w8ddr", 1, 1'b0);
      run_frame(8, 1'b1, 4, -1, 0, 8'h7F, 1'b0, -1);
      expect_frame("w8ddr_endbad", 1, 1'b1);

      wexp[0] = 32'hDEADBEEF;
      run_frame(1, 1'b0, 4, -1, 0, 8'hFF, 1'b1, -1);
      expect_frame("w1_gap", 1, 1'b0);

      wexp[0] = 32'hA1B2C3D4;
      wexp[1] = 32'h5E6F7081;
      for (int i = 2; i < 8; i++) wexp[i] = 32'hF0F0F0F0 ^ 32'(i);
      run_frame(4, 1'b0, 32, -1, 0, 8'hFF, 1'b0, 19);
      repeat (5) @(posedge i_clk);
      #1;
      check("abort.nwords", 32'(got_w.size() - w_base), 32'd2);
      check("abort.done",   32'(done_cnt - d_base),     32'd0);
      if (got_w.size() >= w_base + 2) begin
         check("abort.word0", got_w[w_base],     wexp[0]);
         check("abort.word1", got_w[w_base + 1], wexp[1]);
      end

      wexp[0] = 32'hDEADBEEF;
      run_frame(1, 1'b0, 4, -1, 0, 8'hFF, 1'b0, -1);
      expect_frame("rearm", 1, 1'b0);

`ifdef SDRXFRAME_TIMEOUT_EN
      begin : tmo_blk
         int k;
         i_timeout    = 24'd100;
         bus.rx_valid = 1'b0;
         i_en         = 1'b1;
         @(posedge i_clk); #1;
         k = 0;
         while (k < 200 && !o_done) begin
            @(posedge i_clk); #1;
            k++;
         end
         check("tmo.cycles", 32'(k), 32'd100);
         check("tmo.err", 32'(o_err), 32'd1);
         i_en      = 1'b0;
         i_timeout = 24'd0;
      end
`endif

      check("no_overlap", 32'(overlap), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
